counter_4b: RTL and testbench

Free-running, parameterizable synchronous up-counter with a wrap indicator. The default configuration is a 4-bit binary counter that increments every clock cycle and rolls over from 15 to 0. It sits as a leaf block providing a cycle/sequence count to surrounding pipeline logic and to waveform-based debug. It has no enable or load inputs: it counts every cycle it is not held in reset.

---
 rtl/counter_4b.sv | 67 ++++++
 tb/tb_counter_4b.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/counter_4b.sv
// counter_4b: free-running modulo-MOD up-counter with a registered wrap pulse.
// The counter advances by STEP on every rising clk edge that is not in reset.
// When the advance crosses MOD, wrap is high for the one cycle that follows
// the rollover.
module counter_4b #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 2**WIDTH,
  parameter int STEP      = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // Reject illegal parameter sets while the design is being elaborated.
  if ((WIDTH < 1) || (MOD < 2) || (MOD > (2**WIDTH)) ||
      (STEP < 1) || (STEP >= MOD) ||
      (RESET_VAL < 0) || (RESET_VAL >= MOD)) begin : g_param_check
    $error("counter_4b: illegal parameters WIDTH=%0d MOD=%0d STEP=%0d RESET_VAL=%0d",
           WIDTH, MOD, STEP, RESET_VAL);
  end

  // The arithmetic uses WIDTH+1 bits. This keeps the carry of count+STEP,
  // and it also lets MOD == 2**WIDTH be represented.
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_r;
  logic             wrap_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] count_next_s;
  logic             wrap_next_s;

  // Next count and wrap flag: add STEP, then fold back by MOD on overflow.
  always_comb begin
    sum_s        = {1'b0, count_r} + STEP_W;
    diff_s       = sum_s - MOD_W;
    count_next_s = sum_s[WIDTH-1:0];
    wrap_next_s  = 1'b0;
    if (sum_s >= MOD_W) begin
      count_next_s = diff_s[WIDTH-1:0];
      wrap_next_s  = 1'b1;
    end else begin
      count_next_s = sum_s[WIDTH-1:0];
      wrap_next_s  = 1'b0;
    end
  end

  // State register. The synchronous active-low reset takes priority over counting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= RST_W;
      wrap_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      wrap_r  <= wrap_next_s;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_counter_4b.sv
// tb_counter_4b: this bench drives four parameterisations of counter_4b from
// one shared reset and checks them. Each check compares the DUT against an
// arithmetic model. After k counting edges the model expects
// count = (RESET_VAL + k*STEP) mod MOD. It expects wrap whenever the quotient
// (RESET_VAL + k*STEP) / MOD grew on the last edge.
module tb_counter_4b;

  logic       clk;
  logic       reset;
  logic [3:0] def_count;
  logic       def_wrap;
  logic [3:0] m10_count;
  logic       m10_wrap;
  logic [3:0] s15_count;
  logic       s15_wrap;
  logic [2:0] m5_count;
  logic       m5_wrap;

  int errors = 0;
  int checks = 0;
  int k      = 0;  // counting edges since the last reset edge
  int m10_tab[11] = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
  int m10_wtab[11] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  int s15_tab[4] = '{0, 15, 14, 13};

  counter_4b u_def (
    .clk   (clk),
    .reset (reset),
    .count (def_count),
    .wrap  (def_wrap)
  );

  counter_4b #(.WIDTH(4), .MOD(10), .STEP(3), .RESET_VAL(0)) u_m10 (
    .clk   (clk),
    .reset (reset),
    .count (m10_count),
    .wrap  (m10_wrap)
  );

  counter_4b #(.WIDTH(4), .MOD(16), .STEP(15), .RESET_VAL(0)) u_s15 (
    .clk   (clk),
    .reset (reset),
    .count (s15_count),
    .wrap  (s15_wrap)
  );

  counter_4b #(.WIDTH(3), .MOD(5), .STEP(2), .RESET_VAL(4)) u_m5 (
    .clk   (clk),
    .reset (reset),
    .count (m5_count),
    .wrap  (m5_wrap)
  );

  // Clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mdl_count(int rv, int st, int md, int n);
    return (rv + n * st) % md;
  endfunction

  function automatic int mdl_wrap(int rv, int st, int md, int n);
    if (n == 0) return 0;
    return (((rv + n * st) / md) != ((rv + (n - 1) * st) / md)) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (k=%0d t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  task automatic check_all();
    chk("def_count", 32'(def_count), 32'(mdl_count(0, 1, 16, k)));
    chk("def_wrap",  32'(def_wrap),  32'(mdl_wrap(0, 1, 16, k)));
    chk("m10_count", 32'(m10_count), 32'(mdl_count(0, 3, 10, k)));
    chk("m10_wrap",  32'(m10_wrap),  32'(mdl_wrap(0, 3, 10, k)));
    chk("s15_count", 32'(s15_count), 32'(mdl_count(0, 15, 16, k)));
    chk("s15_wrap",  32'(s15_wrap),  32'(mdl_wrap(0, 15, 16, k)));
    chk("m5_count",  32'(m5_count),  32'(mdl_count(4, 2, 5, k)));
    chk("m5_wrap",   32'(m5_wrap),   32'(mdl_wrap(4, 2, 5, k)));
  endtask

  // Advance one edge. The model looks at reset as it stood at the edge.
  // The DUT is sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    if (reset === 1'b0) k = 0;
    else k = k + 1;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b0;

    // Reset held low for two edges.
    step();
    step();
    chk("rst_count", 32'(def_count), 32'd0);
    chk("rst_wrap",  32'(def_wrap),  32'd0);

    // Release, then free run for 20 edges against the fixed sequence tables.
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk("def_seq", 32'(def_count), 32'(n % 16));
      chk("def_wrap_seq", 32'(def_wrap), (n == 16) ? 32'd1 : 32'd0);
      if (n <= 10) begin
        chk("m10_seq",  32'(m10_count), 32'(m10_tab[n]));
        chk("m10_wseq", 32'(m10_wrap),  32'(m10_wtab[n]));
      end
      if (n <= 3) chk("s15_seq", 32'(s15_count), 32'(s15_tab[n]));
    end

    // Reset in the middle of a count: wait for the default counter to reach 7.
    for (int n = 0; n < 40; n++) begin
      if (def_count == 4'd7) break;
      step();
    end
    chk("mid_at7", 32'(def_count), 32'd7);
    reset = 1'b0;
    step();
    chk("mid_rst0", 32'(def_count), 32'd0);
    chk("mid_nowrap", 32'(def_wrap), 32'd0);
    step();
    chk("mid_hold0", 32'(def_count), 32'd0);
    reset = 1'b1;
    step();
    chk("mid_resume", 32'(def_count), 32'd1);
    step();

    // A 2 ns low pulse strictly between edges must not disturb the count.
    #3 reset = 1'b0;
    #2 reset = 1'b1;
    step();
    chk("glitch_count", 32'(def_count), 32'd3);
    step();
    chk("glitch_next", 32'(def_count), 32'd4);

    // Random run with occasional resets. Reset changes 1 ns after each edge.
    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
